// File: rtl/square_move_ctrl_pkg.sv
// ---------------------------------------------------------------
// square_move_ctrl_pkg : shared direction indices and FSM codes
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package square_move_ctrl_pkg;

  localparam int DIR_U    = 0;
  localparam int DIR_D    = 1;
  localparam int DIR_L    = 2;
  localparam int DIR_R    = 3;
  localparam int NUM_DIRS = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Counter width for a count that must reach n-1; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/square_move_ctrl_btn_debounce_repeat.sv
// ---------------------------------------------------------------
// btn_debounce_repeat : sync, debounce and auto-repeat step pulses
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module btn_debounce_repeat
  import square_move_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step
);

  localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_width(RMAX);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync0, sync1;
  logic          level;
  logic [DW-1:0] db_cnt;
  logic          db_done, rise, fall;
  logic [1:0]    state;
  logic [RW-1:0] rep_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
    end
  end

  assign db_done = (sync1 != level) && (db_cnt == DB_LAST);
  assign rise    = db_done && sync1;
  assign fall    = db_done && !sync1;

  // Level resets high so a button held through reset needs a release first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= 1'b1;
      db_cnt <= '0;
    end else if (sync1 == level) begin
      db_cnt <= '0;
    end else if (db_done) begin
      level  <= sync1;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rep_cnt <= '0;
      step    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (fall) begin
        state   <= ST_IDLE;
        rep_cnt <= '0;
      end else if (rise) begin
        state   <= ST_FIRST;
        rep_cnt <= '0;
        step    <= 1'b1;
      end else begin
        case (state)
          ST_FIRST: begin
            if (rep_cnt == DELAY_LAST) begin
              state   <= ST_REPEAT;
              rep_cnt <= '0;
              step    <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (rep_cnt == PERIOD_LAST) begin
              rep_cnt <= '0;
              step    <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            rep_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/square_move_ctrl.sv
// ---------------------------------------------------------------
// square_move_ctrl : four-button saturating square position control
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module square_move_ctrl
  import square_move_ctrl_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         REPEAT_DELAY    = 50000000,
  parameter int         REPEAT_PERIOD   = 10000000,
  parameter logic [7:0] X_MAX           = 8'd159,
  parameter logic [7:0] Y_MAX           = 8'd119
) (
  input  logic       CLK,
  input  logic       RST_BTN,
  input  logic       BTN_U,
  input  logic       BTN_D,
  input  logic       BTN_L,
  input  logic       BTN_R,
  output logic [7:0] POS_X,
  output logic [7:0] POS_Y,
  output logic       MOVED
);

  localparam logic [7:0] X_HOME = X_MAX >> 1;
  localparam logic [7:0] Y_HOME = Y_MAX >> 1;

  logic [NUM_DIRS-1:0] btns;
  logic [NUM_DIRS-1:0] step;
  logic [7:0]          next_x, next_y;

  always_comb begin
    btns         = '0;
    btns[DIR_U]  = BTN_U;
    btns[DIR_D]  = BTN_D;
    btns[DIR_L]  = BTN_L;
    btns[DIR_R]  = BTN_R;
  end

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_btn
    btn_debounce_repeat #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_btn (
      .clk (CLK),
      .rst (RST_BTN),
      .btn (btns[i]),
      .step(step[i])
    );
  end

  // Opposing steps on one axis cancel; each direction saturates at its limit.
  always_comb begin
    next_x = POS_X;
    next_y = POS_Y;
    if (step[DIR_L] && !step[DIR_R] && POS_X != 8'd0)
      next_x = POS_X - 8'd1;
    else if (step[DIR_R] && !step[DIR_L] && POS_X < X_MAX)
      next_x = POS_X + 8'd1;
    if (step[DIR_U] && !step[DIR_D] && POS_Y != 8'd0)
      next_y = POS_Y - 8'd1;
    else if (step[DIR_D] && !step[DIR_U] && POS_Y < Y_MAX)
      next_y = POS_Y + 8'd1;
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      POS_X <= X_HOME;
      POS_Y <= Y_HOME;
      MOVED <= 1'b0;
    end else begin
      POS_X <= next_x;
      POS_Y <= next_y;
      MOVED <= (next_x != POS_X) || (next_y != POS_Y);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_square_move_ctrl.sv
// ---------------------------------------------------------------
// tb_square_move_ctrl : scoreboard bench with a hold-time step model
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_square_move_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int XM = 159;
  localparam int YM = 119;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;   // index: U=0 D=1 L=2 R=3
  logic [7:0] pos_x, pos_y;
  logic       moved;

  always #5 clk = ~clk;

  square_move_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .X_MAX          (8'd159),
    .Y_MAX          (8'd119)
  ) dut (
    .CLK    (clk),
    .RST_BTN(rst),
    .BTN_U  (btn[0]),
    .BTN_D  (btn[1]),
    .BTN_L  (btn[2]),
    .BTN_R  (btn[3]),
    .POS_X  (pos_x),
    .POS_Y  (pos_y),
    .MOVED  (moved)
  );

  typedef struct {
    int x;
    int y;
    int c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: raw -> 2-cycle delay -> debounced level -> steps by hold time.
  int mx, my, nx, ny, synced;
  int pipe0[4], pipe1[4], lvl[4], run[4], held[4];
  bit stp[4];
  bit ev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mx = 79;
      my = 59;
      q.delete();
      for (int i = 0; i < 4; i++) begin
        pipe0[i] = 0; pipe1[i] = 0; lvl[i] = 1; run[i] = 0; held[i] = -1; stp[i] = 0;
      end
    end else begin
      cyc++;
      nx = mx;
      ny = my;
      if (stp[2] && !stp[3] && nx > 0) nx--;
      else if (stp[3] && !stp[2] && nx < XM) nx++;
      if (stp[0] && !stp[1] && ny > 0) ny--;
      else if (stp[1] && !stp[0] && ny < YM) ny++;
      if (nx != mx || ny != my) q.push_back('{nx, ny, cyc});
      mx = nx;
      my = ny;
      for (int i = 0; i < 4; i++) begin
        synced   = pipe1[i];
        pipe1[i] = pipe0[i];
        pipe0[i] = int'(btn[i]);
        stp[i]   = 0;
        ev       = 0;
        if (synced != lvl[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            lvl[i] = synced;
            run[i] = 0;
            ev     = 1;
          end
        end else begin
          run[i] = 0;
        end
        if (ev) begin
          held[i] = (lvl[i] != 0) ? 0 : -1;
          stp[i]  = (lvl[i] != 0);
        end else if (held[i] >= 0) begin
          held[i]++;
          stp[i] = (held[i] == RD) || (held[i] > RD && ((held[i] - RD) % RP) == 0);
        end
      end
    end
  end

  // Monitor: every MOVED pulse must match the head of the scoreboard queue.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (moved) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL move_unexpected cyc=%0d got x=%0d y=%0d required no MOVED", cyc, pos_x, pos_y);
        end else begin
          e = q.pop_front();
          if (int'(pos_x) != e.x || int'(pos_y) != e.y || cyc != e.c) begin
            errors++;
            $display("FAIL move_value got x=%0d y=%0d cyc=%0d required x=%0d y=%0d cyc=%0d",
                     pos_x, pos_y, cyc, e.x, e.y, e.c);
          end
        end
      end else if (q.size() != 0 && q[0].c <= cyc) begin
        checks++;
        errors++;
        $display("FAIL move_missing cyc=%0d got no MOVED required x=%0d y=%0d", cyc, q[0].x, q[0].y);
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic settle_chk(input string name, input int ex, input int ey);
    @(negedge clk);
    chk({name, "_x"}, int'(pos_x), ex);
    chk({name, "_y"}, int'(pos_y), ey);
    chk({name, "_model_x"}, int'(pos_x), mx);
    chk({name, "_model_y"}, int'(pos_y), my);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    btn = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", int'(pos_x), 79);
    chk("reset_y", int'(pos_y), 59);
    chk("reset_moved", int'(moved), 0);
    #1 rst = 1'b0;

    idle(40);
    settle_chk("idle", 79, 59);

    btn[3] = 1'b1; idle(10);
    btn[3] = 1'b0; idle(30);
    settle_chk("r_pulse", 80, 59);

    for (int k = 0; k < 12; k++) begin
      btn[1] = ((k / 2) % 2) == 0;
      idle(1);
    end
    btn[1] = 1'b1; idle(30);
    btn[1] = 1'b0; idle(30);
    settle_chk("bounce", 80, 62);

    btn[2] = 1'b1; btn[3] = 1'b1; idle(10);
    btn = 4'b0000; idle(30);
    settle_chk("cancel_lr", 80, 62);

    btn[0] = 1'b1; btn[3] = 1'b1; idle(10);
    btn = 4'b0000; idle(30);
    settle_chk("diag_ur", 81, 61);

    btn[3] = 1'b1; idle(800);
    settle_chk("sat_x_max", 159, 61);
    idle(40);
    settle_chk("sat_x_hold", 159, 61);
    btn[3] = 1'b0; idle(30);

    btn[0] = 1'b1; idle(700);
    settle_chk("sat_y_zero", 159, 0);
    btn[0] = 1'b0; idle(30);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
      idle(1);
    end
    btn = 4'b0000; idle(40);
    @(negedge clk);
    chk("random_model_x", int'(pos_x), mx);
    chk("random_model_y", int'(pos_y), my);
    @(posedge clk); #2;

    btn[3] = 1'b1; idle(40);
    rst = 1'b1;
    #1;
    chk("mid_repeat_rst_x", int'(pos_x), 79);
    chk("mid_repeat_rst_y", int'(pos_y), 59);
    chk("mid_repeat_rst_moved", int'(moved), 0);
    idle(2);
    rst = 1'b0;
    idle(60);
    settle_chk("held_thru_rst", 79, 59);
    btn[3] = 1'b0; idle(20);
    btn[3] = 1'b1; idle(10);
    btn[3] = 1'b0; idle(30);
    settle_chk("repress", 80, 59);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/square_move_ctrl.md
SQUARE_MOVE_CTRL -- requirements
Module: square_move_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles before a button level is accepted (10 ms at 100 MHz).
REQ-002 Parameter REPEAT_DELAY, default 50000000, held cycles after the first step before auto-repeat starts.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, cycles between auto-repeat steps.
REQ-004 Parameter X_MAX, default 8'd159, largest legal X coordinate.
REQ-005 Parameter Y_MAX, default 8'd119, largest legal Y coordinate.
REQ-006 Port CLK, input, 1, sole system clock; all state on rising edge.
REQ-007 Port RST_BTN, input, 1, asynchronous active-high reset.
REQ-008 Port BTN_U, BTN_D, BTN_L, BTN_R, input, 1 each, raw asynchronous push buttons, active-high.
REQ-009 Port POS_X, output, 8, square X coordinate, fed directly to the square renderer's first 8-bit input.
REQ-010 Port POS_Y, output, 8, square Y coordinate, fed to the renderer's second 8-bit input.
REQ-011 Port MOVED, output, 1, one-cycle strobe in the cycle POS_X or POS_Y takes a new value.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 Per button, an FSM SHALL use states IDLE, FIRST, REPEAT: IDLE->FIRST on debounced rise (emit one step); FIRST->REPEAT after REPEAT_DELAY held cycles (emit one step); in REPEAT emit one step every REPEAT_PERIOD cycles; any state->IDLE on debounced fall, no step.
REQ-015 Step pulses SHALL be one cycle wide; at most one step per button per cycle.
REQ-016 Steps SHALL be applied the cycle after the pulse; POS_X/POS_Y and MOVED update together (step-to-output latency 1 cycle).
REQ-017 U decrements Y, D increments Y, L decrements X, R increments X, each by exactly 1.
REQ-018 Arithmetic SHALL saturate: no decrement below 0, no increment above X_MAX/Y_MAX; no wrap-around.
REQ-019 A saturated (blocked) step SHALL NOT assert MOVED.
REQ-020 Simultaneous U and D steps SHALL cancel (Y unchanged); same for L and R on X.
REQ-021 Simultaneous steps on different axes SHALL both apply in the same cycle with a single MOVED pulse.
REQ-022 Buttons held during reset SHALL NOT produce a step on reset release until released and pressed again.

Reset
REQ-023 RST_BTN high SHALL immediately force POS_X=X_MAX/2 (79), POS_Y=Y_MAX/2 (59), MOVED=0, all FSMs IDLE, all counters 0, debounced levels 1 (treated as held, per REQ-022).
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL abort that operation with no step emitted.
REQ-025 Synchronizer flops SHALL also be reset asynchronously to 0.

Structure
REQ-026 Direction indices (U=0, D=1, L=2, R=3) and FSM state encodings SHALL live in the shared project constants package/include.
REQ-027 One sub-module btn_debounce_repeat (synchronizer, debounce counter, IDLE/FIRST/REPEAT FSM) SHALL be instantiated four times; position saturation logic stays in square_move_ctrl.
REQ-028 Counters SHALL be sized by $clog2 of their parameter; no latches; no combinational path input to output.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-029 Reset release, no buttons -> POS_X=79, POS_Y=59, MOVED=0 indefinitely.
REQ-030 BTN_R clean pulse held 10 cycles -> after sync+debounce exactly one MOVED, POS_X=80; release -> no further change.
REQ-031 BTN_D bouncing (toggle every 2 cycles for 12 cycles) then stable high 30 cycles -> no step during bounce; one step plus repeat steps at delay 20, then every 8 cycles.
REQ-032 POS_X driven to 159 via BTN_R held -> further repeats leave POS_X=159, MOVED stays 0; BTN_U from POS_Y=0 -> POS_Y stays 0.
REQ-033 BTN_L and BTN_R asserted same cycle -> POS_X unchanged, no MOVED; BTN_U and BTN_R same cycle -> POS_Y-1, POS_X+1, single MOVED.
REQ-034 RST_BTN pulsed during REPEAT with BTN_R held -> position returns to 79/59 asynchronously; no step until BTN_R released and re-pressed.
